psum_trunc_ctrl: RTL
====================

Name: psum_trunc_ctrl

Overview:
Sequences partial-sum accumulation and output truncation for one PE.
- Accumulates a configured number of 2*DATA_WIDTH multiplier products into a wide accumulator.
- Drives the existing `truncator` with the configured shift and emits the DATA_WIDTH result over a valid/ready handshake.
- Repeats for a configured number of output psums, then returns to idle.
- Sits between the PE multiplier output and the psum output FIFO.

Parameters:
DATA_WIDTH, 16, width of emitted psum; product/accumulator width is 2*DATA_WIDTH
SEL_WIDTH, $clog2(DATA_WIDTH), truncator select width (shift port is SEL_WIDTH+1 bits)
CNT_WIDTH, 8, width of accumulation-length and output-count fields

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration can be accepted (IDLE only)
cfg_acc_len  in  CNT_WIDTH  products per psum, legal 1..2^CNT_WIDTH-1
cfg_num_out  in  CNT_WIDTH  psums per job, legal 1..2^CNT_WIDTH-1
cfg_shift  in  SEL_WIDTH+1  truncation LSB position, legal 0..DATA_WIDTH
cfg_err  out  1  one-cycle pulse: illegal config offered and dropped
in_valid  in  1  product valid
in_ready  out  1  product accepted this cycle when in_valid && in_ready
in_prod  in  2*DATA_WIDTH  unsigned product
out_valid  out  1  truncated psum valid
out_ready  in  1  downstream accepts psum
out_data  out  DATA_WIDTH  truncated psum = acc[shift +: DATA_WIDTH]
out_last  out  1  qualifies out_data as final psum of job
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE; acc, counters and out_data all 0.
- Reset outputs: out_valid, out_last, in_ready, cfg_err, busy = 0; cfg_ready = 1.
- Reset mid-operation discards the job and any pending output; no partial output is emitted.
- Registered config fields: acc_len, num_out, shift (latched on cfg accept). Counters: beat_cnt, out_cnt.
- IDLE: cfg_ready=1.
  - cfg_valid with a legal config: latch fields, clear acc/beat_cnt/out_cnt, go to ACCUM.
  - Illegal config (acc_len==0, num_out==0, or shift>DATA_WIDTH): cfg_err=1 for that cycle, stay IDLE.
- ACCUM: in_ready=1. On each accepted beat:
  - acc <= (beat_cnt==0 ? in_prod : acc+in_prod), unsigned modulo 2^(2*DATA_WIDTH); carry-out is dropped.
  - beat_cnt++.
  - When the accepted beat makes beat_cnt==acc_len, go to TRUNC.
  - in_valid low inserts stalls; there is no timeout.
- TRUNC (1 cycle): in_ready=0.
  - out_data <= truncator(acc, shift); out_last <= (out_cnt==num_out-1).
  - Go to EMIT.
- EMIT: out_valid=1. out_data and out_last are held stable until out_valid && out_ready.
  - On handshake: out_valid drops next cycle; out_cnt++; beat_cnt cleared.
  - Next state is IDLE if out_last, else ACCUM.
  - in_ready=0 throughout EMIT (no overlap of the next psum).
- Latency: final product accepted in cycle N gives out_valid at N+2. Minimum psum period is acc_len+2 cycles when out_ready=1.
- acc_len==1: the psum is the single product, truncated.
- shift==DATA_WIDTH selects the upper half of the accumulator. shift==0 selects the lower half.
- cfg_valid outside IDLE is ignored (cfg_ready=0); no cfg_err.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE, ACCUM, TRUNC, EMIT);
  - ACC_WIDTH = 2*DATA_WIDTH;
  - legality check constant MAX_SHIFT = DATA_WIDTH.
- One sub-module: the existing `truncator`, instantiated combinationally on acc/shift and registered in TRUNC.
- Counters and FSM stay in this module.

Test Plan:
- Basic job: cfg acc_len=3, num_out=1, shift=8; products 0x0100, 0x0200, 0x0300 back-to-back → out_data=0x0006, out_last=1, out_valid 2 cycles after 3rd accept, then IDLE.
- Multi-psum with backpressure: acc_len=2, num_out=3, shift=0; out_ready held low 5 cycles on psum 2 → out_data held stable, in_ready=0 throughout; out_last only on psum 3.
- Wrap and high shift (DATA_WIDTH=16): acc_len=2, shift=16; products 0xFFFF_FFFF, 0x0000_0002 → acc=0x0000_0001, out_data=0x0000.
- Illegal configs: shift=17, then acc_len=0, then num_out=0 → cfg_err pulses once each, state stays IDLE, busy=0.
- Input stalls: acc_len=4 with in_valid gapped → accumulation correct, beat count unaffected by idle cycles.
- Reset mid-ACCUM after 2 beats, then new cfg with acc_len=1 → no stale output; first out_data equals only the new product truncated.

Source files
------------

// File: rtl/psum_trunc_ctrl_pkg.sv
// Shared types and constants for the PE partial-sum accumulate/truncate controller.
package psum_trunc_ctrl_pkg;

  localparam int unsigned PSUM_DATA_WIDTH = 16;
  localparam int unsigned ACC_WIDTH       = 2 * PSUM_DATA_WIDTH;
  localparam int unsigned MAX_SHIFT       = PSUM_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    TRUNC,
    EMIT
  } state_t;

endpackage

// File: rtl/truncator.sv
// Selects a DATA_WIDTH window of the wide accumulator starting at bit 'shift'.
module truncator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SEL_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [SEL_WIDTH:0]      shift,
  output logic [DATA_WIDTH-1:0]   data
);

  assign data = DATA_WIDTH'(acc >> shift);

endmodule

// File: rtl/psum_trunc_ctrl.sv
// Accumulates acc_len products per psum, truncates with the configured shift and
// emits num_out psums over a valid/ready handshake before returning to idle.
module psum_trunc_ctrl
  import psum_trunc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PSUM_DATA_WIDTH,
  parameter int unsigned SEL_WIDTH  = $clog2(DATA_WIDTH),
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_WIDTH-1:0]    cfg_acc_len,
  input  logic [CNT_WIDTH-1:0]    cfg_num_out,
  input  logic [SEL_WIDTH:0]      cfg_shift,
  output logic                    cfg_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned AW = 2 * DATA_WIDTH;
  localparam logic [SEL_WIDTH:0] SHIFT_LIMIT = (SEL_WIDTH + 1)'(DATA_WIDTH);

  state_t                 state;
  logic [AW-1:0]          acc;
  logic [CNT_WIDTH-1:0]   beat_cnt;
  logic [CNT_WIDTH-1:0]   out_cnt;
  logic [CNT_WIDTH-1:0]   acc_len;
  logic [CNT_WIDTH-1:0]   num_out;
  logic [SEL_WIDTH:0]     shift;
  logic [DATA_WIDTH-1:0]  trunc_data;
  logic                   cfg_legal;
  logic [CNT_WIDTH-1:0]   beat_next;

  truncator #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_truncator (
    .acc   (acc),
    .shift (shift),
    .data  (trunc_data)
  );

  assign cfg_legal = (cfg_acc_len != '0) && (cfg_num_out != '0) && (cfg_shift <= SHIFT_LIMIT);
  assign beat_next = beat_cnt + 1'b1;

  // Handshake flags are pure decodes of the state register.
  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign cfg_err   = (state == IDLE) && cfg_valid && !cfg_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      beat_cnt <= '0;
      out_cnt  <= '0;
      acc_len  <= '0;
      num_out  <= '0;
      shift    <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid && cfg_legal) begin
            acc_len  <= cfg_acc_len;
            num_out  <= cfg_num_out;
            shift    <= cfg_shift;
            acc      <= '0;
            beat_cnt <= '0;
            out_cnt  <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc      <= (beat_cnt == '0) ? in_prod : acc + in_prod;
            beat_cnt <= beat_next;
            if (beat_next == acc_len) state <= TRUNC;
          end
        end
        TRUNC: begin
          out_data <= trunc_data;
          out_last <= (out_cnt == num_out - 1'b1);
          state    <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_cnt  <= out_cnt + 1'b1;
            beat_cnt <= '0;
            state    <= out_last ? IDLE : ACCUM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
